bf_insert: RTL and testbench

BF_INSERT -- requirements
Module: bf_insert

---
 rtl/bf_insert.sv | 128 ++++++++++++
 tb/tb_bf_insert.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bf_insert.sv
// bf_insert -- bit-field insert engine.
//
// Inserts the low (len+1) bits of src into dst starting at bit pos:
//   out = (dst & ~(mask << pos)) | ((src & mask) << pos)
// Field bits shifted past bit 31 are dropped, never wrapped. The field and
// mask are walked up to pos at STEP bits per cycle, then merged into dst
// in one cycle and held on out until the consumer takes it.
//
// Ports
//   clk        single clock, rising edge
//   rst_n      asynchronous active-low reset
//   in_valid   request valid
//   in_ready   high only in IDLE
//   dst        destination word
//   src        field source (low len+1 bits used)
//   pos        field LSB position within dst
//   len        field width minus 1
//   flush      synchronous abort, returns to IDLE on the next edge
//   out_valid  high only in DONE
//   out_ready  consumer accepts result
//   out        merged result (keeps its last value when idle or flushed)
//   busy       high whenever not IDLE
module bf_insert #(
  parameter int STEP = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] dst,
  input  logic [31:0] src,
  input  logic [4:0]  pos,
  input  logic [4:0]  len,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    MERGE = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [4:0] STEP_K = 5'(STEP);

  state_t      state;
  state_t      state_nxt;
  logic [31:0] dst_r;
  logic [31:0] fld_r;
  logic [31:0] mask_r;
  logic [4:0]  rem_r;
  logic [31:0] out_r;

  logic [31:0] mask_in;
  logic [4:0]  k;
  logic [4:0]  rem_nxt;
  logic        accept;

  // All-ones shifted right leaves exactly len+1 low ones; len=31 keeps all.
  function automatic logic [31:0] field_mask(input logic [4:0] l);
    field_mask = 32'hFFFF_FFFF >> (5'd31 - l);
  endfunction

  function automatic logic [31:0] merge_word(input logic [31:0] d,
                                             input logic [31:0] f,
                                             input logic [31:0] m);
    merge_word = (d & ~m) | f;
  endfunction

  assign mask_in = field_mask(len);
  assign k       = (rem_r < STEP_K) ? rem_r : STEP_K;
  assign rem_nxt = rem_r - k;
  assign accept  = (state == IDLE) && in_valid && !flush;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign out       = out_r;

  always_comb begin
    state_nxt = state;
    if (flush) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:  if (in_valid) state_nxt = (pos != 5'd0) ? SHIFT : MERGE;
        SHIFT: if (rem_nxt == 5'd0) state_nxt = MERGE;
        MERGE: state_nxt = DONE;
        DONE:  if (out_ready) state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      dst_r  <= '0;
      fld_r  <= '0;
      mask_r <= '0;
      rem_r  <= '0;
      out_r  <= '0;
    end else begin
      state <= state_nxt;
      // Capture: field pre-masked so later shifts carry only wanted bits.
      if (accept) begin
        dst_r  <= dst;
        fld_r  <= src & mask_in;
        mask_r <= mask_in;
        rem_r  <= pos;
      end else if ((state == SHIFT) && !flush) begin
        // Walk field/mask toward pos; bits leaving bit 31 are lost.
        fld_r  <= fld_r << k;
        mask_r <= mask_r << k;
        rem_r  <= rem_nxt;
      end
      // Merge: a flush here must leave the previous result untouched.
      if ((state == MERGE) && !flush) begin
        out_r <= merge_word(dst_r, fld_r, mask_r);
      end
    end
  end

endmodule

// File: tb/tb_bf_insert.sv
// Scoreboard bench for bf_insert: stimulus pushes the expected word and
// the edge on which out_valid must rise; a forked monitor pops and checks.
module tb_bf_insert;

  localparam int STEP = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] dst;
  logic [31:0] src;
  logic [4:0]  pos;
  logic [4:0]  len;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out;
  logic        busy;

  bf_insert #(.STEP(STEP)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .dst       (dst),
    .src       (src),
    .pos       (pos),
    .len       (len),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] val;
    int          due;
  } exp_t;

  exp_t        sb[$];
  int          checks   = 0;
  int          failures = 0;
  logic        ready_auto = 1'b0;
  logic [31:0] held;
  logic [31:0] snap;

  function automatic logic [31:0] model(input logic [31:0] d, input logic [31:0] s,
                                        input logic [4:0] p, input logic [4:0] l);
    logic [63:0] m;
    logic [63:0] f;
    m = (64'd1 << (int'(l) + 1)) - 64'd1;
    f = ({32'd0, s} & m) << p;
    m = m << p;
    return (d & ~m[31:0]) | f[31:0];
  endfunction

  function automatic int latency(input logic [4:0] p);
    return (int'(p) + STEP - 1) / STEP + 1;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (ready_auto) out_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic monitor();
    logic prev = 1'b0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev = 1'b0;
      end else begin
        if (out_valid && !prev) begin
          if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_result actual=%h required=none", out);
          end else begin
            e = sb.pop_front();
            chk("result", out, e.val);
            chk("latency", 32'(cyc), 32'(e.due));
          end
          held = out;
        end else if (out_valid) begin
          chk("hold_stable", out, held);
        end
        prev = out_valid;
      end
    end
  endtask

  // Present a request once in_ready is seen; record when out_valid is due.
  task automatic issue(input logic [31:0] d, input logic [31:0] s,
                       input logic [4:0] p, input logic [4:0] l, input bit expect_res);
    int n = 0;
    exp_t e;
    while (!in_ready && n < 200) begin
      tick();
      n++;
    end
    chk("issue_ready", {31'd0, in_ready}, 32'd1);
    dst = d; src = s; pos = p; len = l; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    if (expect_res) begin
      e.val = model(d, s, p, l);
      e.due = cyc + latency(p);
      sb.push_back(e);
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while (!in_ready && n < 200) begin
      tick();
      n++;
    end
    chk("idle_reached", {31'd0, in_ready}, 32'd1);
  endtask

  initial begin
    exp_t e;
    int n;
    rst_n = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
    dst = '0; src = '0; pos = '0; len = '0;
    fork
      monitor();
    join_none

    tick();
    tick();
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_out", out, 32'd0);

    // First edge after release accepts.
    out_ready = 1'b1;
    rst_n = 1'b1;
    issue(32'hFFFF_FFFF, 32'h0, 5'd8, 5'd7, 1'b1);
    chk("model_030", model(32'hFFFF_FFFF, 32'h0, 5'd8, 5'd7), 32'hFFFF_00FF);
    wait_idle();
    issue(32'hDEAD_BEEF, 32'h1234_5678, 5'd0, 5'd31, 1'b1);
    wait_idle();
    chk("full_replace", out, 32'h1234_5678);
    issue(32'h0, 32'h0000_00AB, 5'd28, 5'd7, 1'b1);
    wait_idle();
    chk("upper_discard", out, 32'hB000_0000);

    // Backpressure with a second request held on in_valid.
    out_ready = 1'b0;
    issue(32'h0F0F_0F0F, 32'h0000_0005, 5'd9, 5'd2, 1'b1);
    dst = 32'hAAAA_5555; src = 32'h0000_3C3C; pos = 5'd3; len = 5'd15; in_valid = 1'b1;
    n = 0;
    while (!out_valid && n < 50) begin
      tick();
      n++;
    end
    chk("bp_valid_seen", {31'd0, out_valid}, 32'd1);
    repeat (5) begin
      chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
      chk("bp_busy", {31'd0, busy}, 32'd1);
      tick();
    end
    out_ready = 1'b1;
    tick();
    chk("bp_idle", {31'd0, in_ready}, 32'd1);
    chk("bp_valid_low", {31'd0, out_valid}, 32'd0);
    tick();
    in_valid = 1'b0;
    e.val = model(32'hAAAA_5555, 32'h0000_3C3C, 5'd3, 5'd15);
    e.due = cyc + latency(5'd3);
    sb.push_back(e);
    wait_idle();

    // Flush mid-SHIFT drops the op and leaves out alone.
    snap = out;
    issue(32'h1111_1111, 32'hFFFF_FFFF, 5'd20, 5'd5, 1'b0);
    tick();
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush_busy", {31'd0, busy}, 32'd0);
    chk("flush_in_ready", {31'd0, in_ready}, 32'd1);
    chk("flush_out", out, snap);
    repeat (10) tick();
    chk("flush_out_later", out, snap);

    // Flush beats in_valid in IDLE.
    dst = 32'h1; src = 32'h1; pos = 5'd1; len = 5'd0; in_valid = 1'b1; flush = 1'b1;
    tick();
    in_valid = 1'b0; flush = 1'b0;
    chk("flush_no_accept", {31'd0, busy}, 32'd0);

    // Reset mid-SHIFT: outputs clear at once, no result afterwards.
    issue(32'h2222_2222, 32'h7, 5'd20, 5'd2, 1'b0);
    tick();
    rst_n = 1'b0;
    #1;
    chk("arst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("arst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("arst_out", out, 32'd0);
    tick();
    rst_n = 1'b1;
    issue(32'h0, 32'hF, 5'd4, 5'd3, 1'b1);
    wait_idle();
    chk("post_reset_op", out, 32'h0000_00F0);

    // Random traffic with random backpressure.
    ready_auto = 1'b1;
    for (int i = 0; i < 40; i++) begin
      issue($urandom, $urandom, 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), 1'b1);
      wait_idle();
    end
    ready_auto = 1'b0;
    out_ready = 1'b1;
    repeat (3) tick();
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
